// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared definitions for the multi-channel LED driver.
//   mode_t : per-channel operating mode (OFF / ON / BLINK / PULSE)
//   PWM_W  : width of the optional brightness (duty) field and pwm counter
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/led_blink_chan.sv
// led_blink_chan: one LED channel of led_blink_multi.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick       : one-cycle prescaler tick (time base for BLINK/PULSE)
//   trig       : pulse trigger, level-sampled every clk (PULSE mode only)
//   we         : config write for this channel (already decoded)
//   cfg_mode   : new mode, cfg_half : new half-period in ticks
//   cfg_duty   : (LED_BLINK_MULTI_PWM_EN only) brightness 0..255
//   pwm_cnt    : (LED_BLINK_MULTI_PWM_EN only) shared free-running pwm counter
//   pwm_gate   : (LED_BLINK_MULTI_PWM_EN only) registered brightness gate
//   state      : registered on/off state of the channel
// Priority on one clk: config write > trig > tick.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int HALFW    = 10,
    parameter int DEF_HALF = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             trig,
    input  logic             we,
    input  mode_t            cfg_mode,
    input  logic [HALFW-1:0] cfg_half,
`ifdef LED_BLINK_MULTI_PWM_EN
    input  logic [PWM_W-1:0] cfg_duty,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             pwm_gate,
`endif
    output logic             state
);

    mode_t            mode, mode_nxt;
    logic [HALFW-1:0] half, half_nxt;
    logic [HALFW-1:0] cnt, cnt_nxt;
    logic [HALFW-1:0] h_last;
    logic             active, active_nxt;
    logic             state_nxt;

    // half = 0 behaves as 1, so the terminal count is h-1 with h = max(half,1).
    always_comb begin
        h_last = (half == '0) ? '0 : half - HALFW'(1);
    end

    always_comb begin
        mode_nxt   = mode;
        half_nxt   = half;
        cnt_nxt    = cnt;
        active_nxt = active;
        state_nxt  = state;
        if (we) begin
            // A write swallows any trig or tick arriving in the same cycle.
            mode_nxt   = cfg_mode;
            half_nxt   = cfg_half;
            cnt_nxt    = '0;
            active_nxt = 1'b0;
            state_nxt  = (cfg_mode == MODE_ON);
        end else begin
            case (mode)
                MODE_OFF: begin
                    state_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
                MODE_ON: begin
                    state_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
                MODE_BLINK: begin
                    if (tick) begin
                        if (cnt >= h_last) begin
                            cnt_nxt   = '0;
                            state_nxt = ~state;
                        end else begin
                            cnt_nxt = cnt + HALFW'(1);
                        end
                    end
                end
                MODE_PULSE: begin
                    // Re-trigger restarts the count, extending the pulse.
                    if (trig) begin
                        state_nxt  = 1'b1;
                        cnt_nxt    = '0;
                        active_nxt = 1'b1;
                    end else if (tick && active) begin
                        if (cnt >= h_last) begin
                            state_nxt  = 1'b0;
                            active_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt + HALFW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= MODE_OFF;
            half   <= HALFW'(DEF_HALF);
            cnt    <= '0;
            active <= 1'b0;
            state  <= 1'b0;
        end else begin
            mode   <= mode_nxt;
            half   <= half_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;
            state  <= state_nxt;
        end
    end

`ifdef LED_BLINK_MULTI_PWM_EN
    logic [PWM_W-1:0] duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= {PWM_W{1'b1}};
        end else if (we) begin
            duty <= cfg_duty;
        end
    end

    // Gate is high for duty+1 of every 256 counter values.
    always_ff @(posedge clk) begin
        pwm_gate <= (pwm_cnt <= duty);
    end
`endif

endmodule

// File: rtl/led_blink_multi.sv
// led_blink_multi: parametrised N-channel LED driver with a shared prescaler.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   cfg_we    : one-cycle config write strobe; ignored when cfg_ch >= N
//   cfg_ch    : target channel
//   cfg_mode  : 0=OFF, 1=ON, 2=BLINK, 3=PULSE
//   cfg_half  : half-period / pulse length in ticks (0 behaves as 1)
//   cfg_duty  : (LED_BLINK_MULTI_PWM_EN only) per-channel brightness
//   trig      : per-channel pulse trigger
//   tick_o    : one-cycle prescaler tick, every PRESCALE clk
//   led       : LED drive
// Optional feature macro: LED_BLINK_MULTI_PWM_EN adds cfg_duty and a shared
// 8-bit pwm counter that dims each led by its stored duty.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int PRESCALE = 50000,
    parameter  int HALFW    = 10,
    parameter  int DEF_HALF = 500,
    localparam int CHW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [HALFW-1:0] cfg_half,
`ifdef LED_BLINK_MULTI_PWM_EN
    input  logic [PWM_W-1:0] cfg_duty,
`endif
    input  logic [N-1:0]     trig,
    output logic             tick_o,
    output logic [N-1:0]     led
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pcnt;
    logic          pcnt_last;
    logic          cfg_ok;

    assign pcnt_last = (pcnt == PW'(PRESCALE - 1));

    // tick_o is registered, so it rises the cycle after the wrap value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= pcnt_last;
            pcnt   <= pcnt_last ? '0 : pcnt + PW'(1);
        end
    end

    // Out-of-range channel numbers are possible when N is not a power of 2.
    assign cfg_ok = cfg_we && (32'(cfg_ch) < 32'(N));

`ifdef LED_BLINK_MULTI_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic st;
`ifdef LED_BLINK_MULTI_PWM_EN
        logic gate;
`endif

        led_blink_chan #(
            .HALFW    (HALFW),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick_o),
            .trig     (trig[i]),
            .we       (cfg_ok && (cfg_ch == CHW'(i))),
            .cfg_mode (mode_t'(cfg_mode)),
            .cfg_half (cfg_half),
`ifdef LED_BLINK_MULTI_PWM_EN
            .cfg_duty (cfg_duty),
            .pwm_cnt  (pwm_cnt),
            .pwm_gate (gate),
`endif
            .state    (st)
        );

`ifdef LED_BLINK_MULTI_PWM_EN
        assign led[i] = st & gate;
`else
        assign led[i] = st;
`endif
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Bench for led_blink_multi (default build). A tick-counting reference model
// predicts led and tick_o every cycle; a second N=5 instance covers writes to
// channel numbers beyond N.
module tb_led_blink_multi;

    localparam int N    = 4;
    localparam int P    = 4;
    localparam int HW   = 8;
    localparam int DEFH = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [1:0]    cfg_mode = '0;
    logic [HW-1:0] cfg_half = '0;
    logic [N-1:0]  trig = '0;
    logic          tick_o;
    logic [N-1:0]  led;

    logic          cfg_we5 = 1'b0;
    logic [2:0]    cfg_ch5 = '0;
    logic          tick5;
    logic [4:0]    led5;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: global tick count plus, per channel, the tick count
    // at the last write/trigger. led follows from plain arithmetic on those.
    int   m;
    int   gt;
    int   md [N];
    int   hh [N];
    int   rf [N];
    bit   act [N];
    logic [N-1:0] exp_led;
    logic         exp_tick;

    always #5 clk = ~clk;

    led_blink_multi #(.N(N), .PRESCALE(P), .HALFW(HW), .DEF_HALF(DEFH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .trig     (trig),
        .tick_o   (tick_o),
        .led      (led)
    );

    led_blink_multi #(.N(5), .PRESCALE(P), .HALFW(HW), .DEF_HALF(DEFH)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we5),
        .cfg_ch   (cfg_ch5),
        .cfg_mode (2'd1),
        .cfg_half (8'd1),
        .trig     (5'b0),
        .tick_o   (tick5),
        .led      (led5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m  = 0;
            gt = 0;
            for (int i = 0; i < N; i++) begin
                md[i]  = 0;
                hh[i]  = DEFH;
                rf[i]  = 0;
                act[i] = 1'b0;
            end
        end else begin
            // tick_o seen by the channels at this edge was raised after edge m
            if (m > 0 && m % P == 0) gt++;
            m++;
            for (int i = 0; i < N; i++) begin
                if (cfg_we && int'(cfg_ch) == i) begin
                    md[i]  = int'(cfg_mode);
                    hh[i]  = (cfg_half == 0) ? 1 : int'(cfg_half);
                    rf[i]  = gt;
                    act[i] = 1'b0;
                end else if (md[i] == 3 && trig[i]) begin
                    act[i] = 1'b1;
                    rf[i]  = gt;
                end
            end
        end
        exp_tick = (m > 0 && m % P == 0);
        for (int i = 0; i < N; i++) begin
            case (md[i])
                0:       exp_led[i] = 1'b0;
                1:       exp_led[i] = 1'b1;
                2:       exp_led[i] = (((gt - rf[i]) / hh[i]) % 2) == 1;
                default: exp_led[i] = act[i] && ((gt - rf[i]) < hh[i]);
            endcase
        end
    endtask

    task automatic step(input bit we, input int ch, input int mode, input int half,
                        input logic [N-1:0] tr, input bit r);
        rst      = r;
        cfg_we   = we;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_half = HW'(half);
        trig     = tr;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("led", 32'(led), 32'(exp_led));
        check("tick_o", 32'(tick_o), 32'(exp_tick));
        rst     = 1'b0;
        cfg_we  = 1'b0;
        cfg_we5 = 1'b0;
        trig    = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, '0, 1'b0);
    endtask

    // Runs n cycles and checks the spacing between led[ch] toggles.
    task automatic toggle_gap(input int ch, input int n, input int gap, input string tag);
        int   last;
        logic p;
        int   seen;
        last = -1;
        seen = 0;
        p    = led[ch];
        for (int k = 0; k < n; k++) begin
            idle(1);
            if (led[ch] !== p) begin
                if (last >= 0) begin
                    check(tag, 32'(cyc - last), 32'(gap));
                    seen++;
                end
                last = cyc;
                p    = led[ch];
            end
        end
        check({tag, "_seen"}, 32'(seen >= 2), 32'd1);
    endtask

    initial begin
        int  len;
        int  k;
        bit  we;
        bit  r;
        logic [N-1:0] tr;

        // Reset and idle: all off, tick every P cycles
        step(1'b0, 0, 0, 0, '0, 1'b1);
        step(1'b0, 0, 0, 0, '0, 1'b1);
        idle(40);

        // BLINK ch0 half=3: toggles every 12 clk
        step(1'b1, 0, 2, 3, '0, 1'b0);
        toggle_gap(0, 70, 12, "blink0_gap");

        // PULSE ch1 half=2
        step(1'b1, 1, 3, 2, '0, 1'b0);
        idle(3);
        step(1'b0, 0, 0, 0, 4'b0010, 1'b0);
        check("pulse_rise", 32'(led[1]), 32'd1);
        len = 1;
        for (k = 0; k < 20; k++) begin
            idle(1);
            if (led[1] !== 1'b1) break;
            len++;
        end
        check("pulse_len", 32'(len >= 5 && len <= 8), 32'd1);
        step(1'b0, 0, 0, 0, 4'b0010, 1'b0);
        idle(4);
        step(1'b0, 0, 0, 0, 4'b0010, 1'b0);
        idle(14);

        // ON then OFF on ch2; out-of-range writes on the N=5 instance
        step(1'b1, 2, 1, 0, '0, 1'b0);
        check("ch2_on", 32'(led[2]), 32'd1);
        step(1'b1, 2, 0, 0, '0, 1'b0);
        check("ch2_off", 32'(led[2]), 32'd0);
        cfg_we5 = 1'b1; cfg_ch5 = 3'd5;
        step(1'b0, 0, 0, 0, '0, 1'b0);
        check("oor_ch5", 32'(led5), 32'd0);
        cfg_we5 = 1'b1; cfg_ch5 = 3'd7;
        step(1'b0, 0, 0, 0, '0, 1'b0);
        check("oor_ch7", 32'(led5), 32'd0);
        cfg_we5 = 1'b1; cfg_ch5 = 3'd4;
        step(1'b0, 0, 0, 0, '0, 1'b0);
        check("inrange_ch4", 32'(led5), 32'h10);

        // BLINK ch3 half=0 acts as half=1: toggles every tick
        step(1'b1, 3, 2, 0, '0, 1'b0);
        toggle_gap(3, 30, 4, "blink3_gap");

        // Reset mid-blink
        idle(5);
        step(1'b0, 0, 0, 0, '0, 1'b1);
        check("rst_led", 32'(led), 32'd0);
        k = 0;
        do begin
            idle(1);
            k++;
        end while (tick_o !== 1'b1 && k < 12);
        check("rst_tick_gap", 32'(k), 32'd4);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            we = ($urandom_range(0, 14) == 0);
            r  = ($urandom_range(0, 599) == 0);
            tr = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            step(we, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)), tr, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
